// File: rtl/vga_fb_pkg.sv
// Shared types and defaults for the framebuffer arbiter.
//   owner_e    : who issued the read travelling down the tag pipe
//   arb_mode_e : which requester has priority this cycle
//   FB_AW/FB_DW: default framebuffer word-address and pixel widths
package vga_fb_pkg;

  localparam int FB_AW = 17;  // 320x240 = 76800 words
  localparam int FB_DW = 8;

  typedef enum logic [1:0] {OWN_NONE, OWN_DISP, OWN_CPU} owner_e;
  typedef enum logic {MODE_DISP, MODE_CPU} arb_mode_e;

endpackage

// File: rtl/vga_fb_arbiter.sv
// Arbiter sharing one single-port framebuffer RAM between the display fetch
// path and the CPU load/store port.
//
// Ports:
//   clk_50MHz, reset                      : clock, synchronous active-high reset
//   video_on                              : display area active (display priority)
//   disp_req/disp_addr -> disp_gnt        : display read request / accept
//   disp_rvalid/disp_rdata                : display read return
//   cpu_valid/cpu_we/cpu_addr/cpu_wdata   : CPU request
//   cpu_ready                             : CPU request accept
//   cpu_rvalid/cpu_rdata                  : CPU read return
//   mem_en/mem_we/mem_addr/mem_wdata      : registered RAM command
//   mem_rdata                             : RAM read data, one cycle after command
//
// Grant at t, command on the RAM port at t+1, read data + rvalid at t+2.
module vga_fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter int AW         = FB_AW,
  parameter int DW         = FB_DW,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk_50MHz,
  input  logic          reset,
  input  logic          video_on,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic          disp_gnt,
  output logic          disp_rvalid,
  output logic [DW-1:0] disp_rdata,
  input  logic          cpu_valid,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ready,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  arb_mode_e  mode;
  logic       disp_win;
  logic       cpu_win;
  logic [3:0] starve_cnt;
  owner_e     own_p0;
  owner_e     own_p1;
  owner_e     own_p2;

  assign mode = video_on ? MODE_DISP : MODE_CPU;

  // Stage p0: combinational grant from current requests and starvation state.
  // The CPU wins a conflict in CPU mode, or in display mode once it has lost
  // STARVE_MAX conflicts in a row. Nothing is granted while in reset.
  always_comb begin
    disp_win = 1'b0;
    cpu_win  = 1'b0;
    if (!reset) begin
      if (cpu_valid && (!disp_req || mode == MODE_CPU || starve_cnt == STARVE_LIM)) begin
        cpu_win = 1'b1;
      end else if (disp_req) begin
        disp_win = 1'b1;
      end
    end
  end

  assign disp_gnt  = disp_win;
  assign cpu_ready = cpu_win;

  // Tag of the access issued this cycle; writes produce no return.
  always_comb begin
    own_p0 = OWN_NONE;
    if (disp_win) begin
      own_p0 = OWN_DISP;
    end else if (cpu_win && !cpu_we) begin
      own_p0 = OWN_CPU;
    end
  end

  // Counts consecutive cycles the CPU waited; saturates at the limit.
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      starve_cnt <= 4'd0;
    end else if (cpu_win) begin
      starve_cnt <= 4'd0;
    end else if (cpu_valid && starve_cnt != STARVE_LIM) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Stage p1: registered RAM command. Address/data hold when idle; write
  // data only changes on a CPU grant since the display never writes.
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= disp_win | cpu_win;
      mem_we <= cpu_win & cpu_we;
      if (cpu_win) begin
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
      end else if (disp_win) begin
        mem_addr <= disp_addr;
      end
    end
  end

  // Stage p1 -> p2: owner tag pipe; reset drops any in-flight reads.
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      own_p1 <= OWN_NONE;
      own_p2 <= OWN_NONE;
    end else begin
      own_p1 <= own_p0;
      own_p2 <= own_p1;
    end
  end

  // Stage p2: read return, aligned with mem_rdata.
  assign disp_rvalid = (own_p2 == OWN_DISP);
  assign cpu_rvalid  = (own_p2 == OWN_CPU);
  assign disp_rdata  = mem_rdata;
  assign cpu_rdata   = mem_rdata;

endmodule
